ram_mfc_controller: RTL

//  Byte-addressed data/instruction RAM with a memory-function handshake for control_unit.

---
 rtl/arm_mem_pkg.sv | 40 ++++
 rtl/ram_byte_array.sv | 26 ++
 rtl/ram_mfc_controller.sv | 120 ++++++++++++
 3 files changed

// File: rtl/arm_mem_pkg.sv
// Shared memory-interface definitions for control_unit and ram_mfc_controller:
// access-size encodings, handshake FSM states and byte-lane helpers.
package arm_mem_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Lane k holds byte address A+k; lane 0 is the most significant byte (big-endian).
    function automatic logic [3:0] lane_enables(input logic [1:0] sz);
        case (sz)
            SIZE_BYTE: return 4'b0001;
            SIZE_HALF: return 4'b0011;
            default:   return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] place_wdata(input logic [31:0] d, input logic [1:0] sz);
        case (sz)
            SIZE_BYTE: return {d[7:0], 24'h0};
            SIZE_HALF: return {d[15:0], 16'h0};
            default:   return d;
        endcase
    endfunction

    function automatic logic [31:0] extend_read(input logic [31:0] rd, input logic [1:0] sz);
        case (sz)
            SIZE_BYTE: return {24'h0, rd[31:24]};
            SIZE_HALF: return {16'h0, rd[31:16]};
            default:   return rd;
        endcase
    endfunction

endpackage

// File: rtl/ram_byte_array.sv
// Byte-addressed RAM presenting four consecutive bytes starting at addr;
// synchronous per-lane write, combinational read, addresses wrap modulo depth.
module ram_byte_array #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic [3:0]        we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    logic [7:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (we[k]) mem[addr + ADDR_W'(k)] <= wdata[31-8*k -: 8];
        end
    end

    assign rdata = {mem[addr],
                    mem[addr + ADDR_W'(1)],
                    mem[addr + ADDR_W'(2)],
                    mem[addr + ADDR_W'(3)]};

endmodule

// File: rtl/ram_mfc_controller.sv
// RAM front end for control_unit: samples an MFA request, waits WAIT_STATES
// cycles, performs the aligned big-endian access and holds MFC until MFA drops.
module ram_mfc_controller
    import arm_mem_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int WAIT_STATES = 2
) (
    input  logic        CLK,
    input  logic        CLR,
    input  logic        MFA,
    input  logic        RW_RAM,
    input  logic [1:0]  SIZE,
    input  logic [31:0] Address,
    input  logic [31:0] DataIn,
    output logic [31:0] DataOut,
    output logic        MFC,
    output logic        Busy
);

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              mfc_d;
    logic              req_load;
    logic              do_access;

    logic [ADDR_W-1:0] addr_q;
    logic              rw_q;
    logic [1:0]        size_q;
    logic [31:0]       wdata_q;

    logic [3:0]        ram_we;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_rdata;
    logic              unused_addr_bits;

    assign unused_addr_bits = ^Address[31:ADDR_W];

    // Misaligned halfword/word addresses are silently rounded down.
    function automatic logic [ADDR_W-1:0] align_addr(input logic [ADDR_W-1:0] a,
                                                     input logic [1:0]        sz);
        case (sz)
            SIZE_BYTE: return a;
            SIZE_HALF: return {a[ADDR_W-1:1], 1'b0};
            default:   return {a[ADDR_W-1:2], 2'b00};
        endcase
    endfunction

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mfc_d     = MFC;
        req_load  = 1'b0;
        do_access = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (MFA) begin
                    req_load = 1'b1;
                    cnt_d    = 4'(WAIT_STATES);
                    state_d  = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    do_access = 1'b1;
                    mfc_d     = 1'b1;
                    state_d   = S_DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_DONE: begin
                if (!MFA) begin
                    mfc_d   = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            MFC     <= 1'b0;
            DataOut <= 32'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            MFC     <= mfc_d;
            if (do_access && rw_q) DataOut <= extend_read(ram_rdata, size_q);
        end
    end

    // Request fields are only meaningful once the FSM has left IDLE.
    always_ff @(posedge CLK) begin
        if (req_load) begin
            addr_q  <= align_addr(Address[ADDR_W-1:0], SIZE);
            rw_q    <= RW_RAM;
            size_q  <= SIZE;
            wdata_q <= DataIn;
        end
    end

    assign Busy      = (state_q != S_IDLE);
    assign ram_we    = (do_access && !rw_q) ? lane_enables(size_q) : 4'b0000;
    assign ram_wdata = place_wdata(wdata_q, size_q);

    ram_byte_array #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (CLK),
        .we    (ram_we),
        .addr  (addr_q),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

endmodule
